window_scheduler: RTL and testbench
===================================

// Module: window_scheduler
// PURPOSE
//  Control sequencer for the multi-scale sliding-window linelength datapath (1s/5s/30s/240s chains).
//  Counts accepted input samples and emits one-cycle shift strobes for each window chain.
//  Emits per-window "full" flags and a valid/ready handshake for the 240s result, which refreshes every 30s.
//  Sits between the sample source and the window shift-register chains; it contains no datapath arithmetic.
// PARAMETERS
//  SAMPLES_PER_SEC  250  samples per 1s window; sample-counter terminal count
//  N_5S             5    1s windows per 5s window
//  N_30S            6    5s windows per 30s window
//  N_240S           8    30s windows per 240s window
// PORTS
//  clk           in   1  system clock, rising edge
//  rst           in   1  asynchronous reset, active-low; clears all state
//  en            in   1  enable, active-low (0 = run, 1 = pause)
//  sample_valid  in   1  a new input sample is present this cycle
//  tick_1s       out  1  one-cycle strobe: shift the 1s-sum into the 5s chain
//  tick_5s       out  1  one-cycle strobe: shift the 5s-sum into the 30s chain
//  tick_30s      out  1  one-cycle strobe: shift the 30s-sum into the 240s chain
//  tick_240s     out  1  one-cycle strobe: one full 240s period completed
//  valid_1s      out  1  sticky flag: 1s chain full
//  valid_5s      out  1  sticky flag: 5s chain full
//  valid_30s     out  1  sticky flag: 30s chain full
//  valid_240s    out  1  sticky flag: 240s chain full
//  result_valid  out  1  240s result available; held until accepted
//  result_ready  in   1  consumer accepts the result
//  state         out  2  FSM state: 00 IDLE, 01 FILL, 10 RUN
// BEHAVIOUR
//  - Reset: all outputs 0, state = IDLE, all counters 0.
//  - A sample is accepted when sample_valid = 1 and en = 0. With en = 1, samples are ignored and counters hold.
//  - sc counter, width $clog2(SAMPLES_PER_SEC):
//      increments on each accepted sample;
//      on an accepted sample at sc == SAMPLES_PER_SEC-1, it wraps to 0 and raises a 1s event.
//  - c5, c30 and c240 count 1s, 5s and 30s events, wrapping at N_5S-1, N_30S-1 and N_240S-1.
//      A wrap raises the next-level event in the same cycle as the event that caused it.
//  - All tick_* outputs are registered: asserted exactly 1 cycle after the accepted sample that caused them.
//      Coincident ticks assert together (e.g. the 60000th sample raises all four).
//  - valid_X is set, and stays set until reset, on the first tick_X.
//  - FSM:
//      IDLE -> FILL when en = 0 and valid_240s = 0.
//      IDLE -> RUN  when en = 0 and valid_240s = 1.
//      FILL -> RUN  on the first tick_240s.
//      FILL or RUN -> IDLE whenever en = 1.
//      Counters and valid flags are preserved across IDLE.
//  - Result handshake:
//      result_valid is set in the cycle tick_30s asserts, when valid_240s is already 1 or is being set in that cycle.
//      result_valid clears on result_valid & result_ready, unless a new set event occurs in the same cycle (then it stays 1).
//      The set event is not gated by en.
//      If result_valid = 1 and result_ready = 0 when a new set event occurs, result_valid stays 1 and the
//      datapath result is overwritten; this is an overrun.
//  - Reset mid-operation clears everything immediately; pending ticks are lost.
// CONFIGURATION
//  - WINDOW_SCHED_OVERRUN_EN defined:
//      adds output overrun (1 bit, sticky, cleared only by reset), set on any overrun;
//      adds output overrun_cnt (8 bits, saturates at 255), incremented on each overrun.
//  - WINDOW_SCHED_OVERRUN_EN undefined: neither port exists and overruns are silent. All other behaviour is identical.
// TESTING
//  1. Hold rst = 0 mid-stream at sc = 100. Required: all outputs 0 and state = 00 asynchronously;
//     after release, the first tick_1s needs 250 more accepted samples.
//  2. Drive 250 back-to-back samples with en = 0. Required: tick_1s high for exactly 1 cycle, 1 cycle after
//     sample 250; valid_1s = 1; no other tick.
//  3. Override SAMPLES_PER_SEC = 4 and drive 4*5*6*8 = 960 samples. Required: tick_1s/5s/30s/240s all asserted
//     together after sample 960; valid_240s = 1, result_valid = 1, state = RUN.
//  4. Drive en = 1 for 50 cycles with sample_valid = 1 at sc = 3. Required: state = IDLE, sc stays 3, no ticks;
//     on en = 0 the FSM returns to the prior FILL/RUN state.
//  5. In RUN, hold result_ready = 0 across two tick_30s events. Required: result_valid stays 1;
//     with the macro, overrun = 1 and overrun_cnt = 1. Then pulse result_ready for 1 cycle -> result_valid = 0.
//  6. Assert result_ready in the same cycle as a set event. Required: result_valid remains 1 and no overrun is counted.

Source files
------------

// File: rtl/window_scheduler_if.sv
// Handshake and strobe bundle for window_scheduler.
// Overrun monitor signals exist only when WINDOW_SCHED_OVERRUN_EN is defined.
interface window_scheduler_if;
    logic       en;
    logic       sample_valid;
    logic       result_ready;
    logic       tick_1s;
    logic       tick_5s;
    logic       tick_30s;
    logic       tick_240s;
    logic       valid_1s;
    logic       valid_5s;
    logic       valid_30s;
    logic       valid_240s;
    logic       result_valid;
    logic [1:0] state;
`ifdef WINDOW_SCHED_OVERRUN_EN
    logic       overrun;
    logic [7:0] overrun_cnt;
`endif

    // Sample source / result consumer side.
    modport master (
        output en, sample_valid, result_ready,
        input  tick_1s, tick_5s, tick_30s, tick_240s,
        input  valid_1s, valid_5s, valid_30s, valid_240s,
        input  result_valid, state
`ifdef WINDOW_SCHED_OVERRUN_EN
        , input overrun, overrun_cnt
`endif
    );

    // Scheduler side.
    modport slave (
        input  en, sample_valid, result_ready,
        output tick_1s, tick_5s, tick_30s, tick_240s,
        output valid_1s, valid_5s, valid_30s, valid_240s,
        output result_valid, state
`ifdef WINDOW_SCHED_OVERRUN_EN
        , output overrun, overrun_cnt
`endif
    );
endinterface

// File: rtl/window_scheduler.sv
// Sample/1s/5s/30s/240s strobe sequencer with 240s-result valid/ready handshake.
// Define WINDOW_SCHED_OVERRUN_EN to add the sticky overrun flag and saturating overrun counter.
module window_scheduler #(
    parameter int unsigned SAMPLES_PER_SEC = 250,
    parameter int unsigned N_5S            = 5,
    parameter int unsigned N_30S           = 6,
    parameter int unsigned N_240S          = 8
) (
    input logic               clk,
    input logic               rst,
    window_scheduler_if.slave bus
);
    localparam int unsigned ScW   = (SAMPLES_PER_SEC > 1) ? $clog2(SAMPLES_PER_SEC) : 1;
    localparam int unsigned C5W   = (N_5S > 1) ? $clog2(N_5S) : 1;
    localparam int unsigned C30W  = (N_30S > 1) ? $clog2(N_30S) : 1;
    localparam int unsigned C240W = (N_240S > 1) ? $clog2(N_240S) : 1;

    localparam logic [ScW-1:0]   ScLast   = ScW'(SAMPLES_PER_SEC - 1);
    localparam logic [C5W-1:0]   C5Last   = C5W'(N_5S - 1);
    localparam logic [C30W-1:0]  C30Last  = C30W'(N_30S - 1);
    localparam logic [C240W-1:0] C240Last = C240W'(N_240S - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StFill = 2'b01,
        StRun  = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [ScW-1:0]   sc_q, sc_d;
    logic [C5W-1:0]   c5_q, c5_d;
    logic [C30W-1:0]  c30_q, c30_d;
    logic [C240W-1:0] c240_q, c240_d;

    logic accept;
    logic ev_1s, ev_5s, ev_30s, ev_240s;
    logic tick_1s_q, tick_5s_q, tick_30s_q, tick_240s_q;
    logic valid_1s_q, valid_5s_q, valid_30s_q, valid_240s_q;
    logic result_valid_q, result_valid_d, result_set;

    assign accept = bus.sample_valid & ~bus.en;

    // Cascaded counters; each wrap raises the next-level event in the same cycle.
    always_comb begin
        sc_d    = sc_q;
        c5_d    = c5_q;
        c30_d   = c30_q;
        c240_d  = c240_q;
        ev_1s   = 1'b0;
        ev_5s   = 1'b0;
        ev_30s  = 1'b0;
        ev_240s = 1'b0;
        if (accept) begin
            if (sc_q == ScLast) begin
                sc_d  = '0;
                ev_1s = 1'b1;
            end else begin
                sc_d = sc_q + ScW'(1);
            end
        end
        if (ev_1s) begin
            if (c5_q == C5Last) begin
                c5_d  = '0;
                ev_5s = 1'b1;
            end else begin
                c5_d = c5_q + C5W'(1);
            end
        end
        if (ev_5s) begin
            if (c30_q == C30Last) begin
                c30_d  = '0;
                ev_30s = 1'b1;
            end else begin
                c30_d = c30_q + C30W'(1);
            end
        end
        if (ev_30s) begin
            if (c240_q == C240Last) begin
                c240_d  = '0;
                ev_240s = 1'b1;
            end else begin
                c240_d = c240_q + C240W'(1);
            end
        end
    end

    // A new 240s result appears each 30s once the 240s chain holds (or is completing) a full window.
    assign result_set     = tick_30s_q & (valid_240s_q | tick_240s_q);
    assign result_valid_d = result_set | (result_valid_q & ~bus.result_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_q           <= '0;
            c5_q           <= '0;
            c30_q          <= '0;
            c240_q         <= '0;
            tick_1s_q      <= 1'b0;
            tick_5s_q      <= 1'b0;
            tick_30s_q     <= 1'b0;
            tick_240s_q    <= 1'b0;
            valid_1s_q     <= 1'b0;
            valid_5s_q     <= 1'b0;
            valid_30s_q    <= 1'b0;
            valid_240s_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            sc_q           <= sc_d;
            c5_q           <= c5_d;
            c30_q          <= c30_d;
            c240_q         <= c240_d;
            tick_1s_q      <= ev_1s;
            tick_5s_q      <= ev_5s;
            tick_30s_q     <= ev_30s;
            tick_240s_q    <= ev_240s;
            valid_1s_q     <= valid_1s_q | tick_1s_q;
            valid_5s_q     <= valid_5s_q | tick_5s_q;
            valid_30s_q    <= valid_30s_q | tick_30s_q;
            valid_240s_q   <= valid_240s_q | tick_240s_q;
            result_valid_q <= result_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!bus.en) begin
                    state_d = valid_240s_q ? StRun : StFill;
                end
            end
            StFill: begin
                if (bus.en) begin
                    state_d = StIdle;
                end else if (tick_240s_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.state        = state_q;
        bus.tick_1s      = tick_1s_q;
        bus.tick_5s      = tick_5s_q;
        bus.tick_30s     = tick_30s_q;
        bus.tick_240s    = tick_240s_q;
        bus.valid_1s     = valid_1s_q;
        bus.valid_5s     = valid_5s_q;
        bus.valid_30s    = valid_30s_q;
        bus.valid_240s   = valid_240s_q;
        bus.result_valid = result_valid_q;
    end

`ifdef WINDOW_SCHED_OVERRUN_EN
    logic       overrun_evt;
    logic       overrun_q;
    logic [7:0] overrun_cnt_q;

    // Unconsumed result overwritten; a coincident accept is not an overrun.
    assign overrun_evt = result_set & result_valid_q & ~bus.result_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q     <= 1'b0;
            overrun_cnt_q <= 8'd0;
        end else if (overrun_evt) begin
            overrun_q <= 1'b1;
            if (overrun_cnt_q != 8'hff) begin
                overrun_cnt_q <= overrun_cnt_q + 8'd1;
            end
        end
    end

    assign bus.overrun     = overrun_q;
    assign bus.overrun_cnt = overrun_cnt_q;
`endif
endmodule

// File: tb/tb_window_scheduler.sv
// Bench for window_scheduler: full-size instance for 1s timing and async reset,
// 4-samples/s instance for the 240s path, handshake corners and random stimulus vs. a count model.
module tb_window_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    window_scheduler_if bus_big ();
    window_scheduler_if bus_small ();

    window_scheduler u_big (
        .clk (clk),
        .rst (rst),
        .bus (bus_big)
    );

    window_scheduler #(
        .SAMPLES_PER_SEC (4),
        .N_5S            (5),
        .N_30S           (6),
        .N_240S          (8)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_small)
    );

    typedef struct {
        int         reps;
        logic       en;
        logic       sv;
        logic       rr;
        logic [3:0] ticks;
        logic [3:0] valids;
        logic [1:0] state;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: accepted-sample count; tick k fires when the count hits a multiple of per[k].
    int         per [4] = '{4, 20, 120, 960};
    int         n_acc;
    logic [3:0] m_tick;
    logic [3:0] m_valid;
    logic       m_rv;
    logic [1:0] m_state;
`ifdef WINDOW_SCHED_OVERRUN_EN
    logic       m_ovr;
    int         m_ocnt;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ticks_big();
        return {bus_big.tick_240s, bus_big.tick_30s, bus_big.tick_5s, bus_big.tick_1s};
    endfunction

    function automatic logic [3:0] valids_big();
        return {bus_big.valid_240s, bus_big.valid_30s, bus_big.valid_5s, bus_big.valid_1s};
    endfunction

    function automatic logic [3:0] ticks_small();
        return {bus_small.tick_240s, bus_small.tick_30s, bus_small.tick_5s, bus_small.tick_1s};
    endfunction

    function automatic logic [3:0] valids_small();
        return {bus_small.valid_240s, bus_small.valid_30s, bus_small.valid_5s,
                bus_small.valid_1s};
    endfunction

    function automatic logic [10:0] outs_big();
        return {ticks_big(), valids_big(), bus_big.result_valid, bus_big.state};
    endfunction

    function automatic logic [10:0] outs_small();
        return {ticks_small(), valids_small(), bus_small.result_valid, bus_small.state};
    endfunction

    task automatic model_reset();
        n_acc   = 0;
        m_tick  = 4'h0;
        m_valid = 4'h0;
        m_rv    = 1'b0;
        m_state = 2'b00;
`ifdef WINDOW_SCHED_OVERRUN_EN
        m_ovr   = 1'b0;
        m_ocnt  = 0;
`endif
    endtask

    task automatic model_step(input logic en, input logic sv, input logic rr);
        logic [3:0] pt;
        logic [3:0] pv;
        logic       prv;
        logic       set;
        logic [1:0] ps;
        logic       acc;
        pt  = m_tick;
        pv  = m_valid;
        prv = m_rv;
        ps  = m_state;
        acc = sv && !en;
        if (acc) n_acc++;
        for (int k = 0; k < 4; k++) m_tick[k] = acc && (n_acc % per[k] == 0);
        m_valid = pv | pt;
        set     = pt[2] && (pv[3] || pt[3]);
        m_rv    = set || (prv && !rr);
`ifdef WINDOW_SCHED_OVERRUN_EN
        if (set && prv && !rr) begin
            m_ovr = 1'b1;
            if (m_ocnt < 255) m_ocnt++;
        end
`endif
        if (en) m_state = 2'b00;
        else if (ps == 2'b00) m_state = pv[3] ? 2'b10 : 2'b01;
        else if (ps == 2'b01 && pt[3]) m_state = 2'b10;
    endtask

    task automatic small_step(input logic en, input logic sv, input logic rr);
        bus_small.en           = en;
        bus_small.sample_valid = sv;
        bus_small.result_ready = rr;
        @(posedge clk);
        model_step(en, sv, rr);
        #1;
        check("model_ticks", 32'(ticks_small()), 32'(m_tick));
        check("model_valids", 32'(valids_small()), 32'(m_valid));
        check("model_result_valid", 32'(bus_small.result_valid), 32'(m_rv));
        check("model_state", 32'(bus_small.state), 32'(m_state));
`ifdef WINDOW_SCHED_OVERRUN_EN
        check("model_overrun", 32'(bus_small.overrun), 32'(m_ovr));
        check("model_overrun_cnt", 32'(bus_small.overrun_cnt), 32'(m_ocnt));
`endif
    endtask

    task automatic run_to(input int target);
        while (n_acc < target) small_step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic big_step(input logic sv);
        bus_big.en           = 1'b0;
        bus_big.sample_valid = sv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [9];
        logic [3:0] seen;

        // Pause at sc=3 for 50 cycles, resume, then the 4th sample gives the first 1s tick.
        tbl[0] = '{1,  1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00};
        tbl[1] = '{1,  1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b01};
        tbl[2] = '{1,  1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b01};
        tbl[3] = '{1,  1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b01};
        tbl[4] = '{1,  1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 2'b01};
        tbl[5] = '{50, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 2'b00};
        tbl[6] = '{1,  1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b01};
        tbl[7] = '{1,  1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 2'b01};
        tbl[8] = '{1,  1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 2'b01};

        bus_big.en             = 1'b0;
        bus_big.sample_valid   = 1'b0;
        bus_big.result_ready   = 1'b0;
        bus_small.en           = 1'b1;
        bus_small.sample_valid = 1'b0;
        bus_small.result_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_big_outputs", 32'(outs_big()), 32'd0);
        check("reset_small_outputs", 32'(outs_small()), 32'd0);
        rst = 1'b1;

        // 250 back-to-back samples: one 1s tick right after the 250th.
        for (int i = 1; i <= 250; i++) begin
            big_step(1'b1);
            check("t2_tick", 32'(ticks_big()), (i == 250) ? 32'd1 : 32'd0);
        end
        big_step(1'b0);
        check("t2_tick_one_cycle", 32'(ticks_big()), 32'd0);
        check("t2_valids", 32'(valids_big()), 32'd1);
        check("t2_state_fill", 32'(bus_big.state), 32'd1);

        // Reset mid-stream at sc=100 clears outputs without a clock edge.
        for (int i = 0; i < 100; i++) big_step(1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("t1_async_reset_outputs", 32'(outs_big()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 4'h0;
        for (int i = 0; i < 249; i++) begin
            big_step(1'b1);
            seen = seen | ticks_big();
        end
        check("t1_no_early_tick", 32'(seen), 32'd0);
        big_step(1'b1);
        check("t1_tick_after_250", 32'(ticks_big()), 32'd1);
        big_step(1'b0);

        // Small instance from a clean reset.
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) small_step(tbl[i].en, tbl[i].sv, tbl[i].rr);
            check("tbl_ticks", 32'(ticks_small()), 32'(tbl[i].ticks));
            check("tbl_valids", 32'(valids_small()), 32'(tbl[i].valids));
            check("tbl_state", 32'(bus_small.state), 32'(tbl[i].state));
        end

        // 960th sample raises all four ticks together.
        run_to(959);
        small_step(1'b0, 1'b1, 1'b0);
        check("t3_all_ticks", 32'(ticks_small()), 32'hf);
        small_step(1'b0, 1'b0, 1'b0);
        check("t3_valids", 32'(valids_small()), 32'hf);
        check("t3_result_valid", 32'(bus_small.result_valid), 32'd1);
        check("t3_state_run", 32'(bus_small.state), 32'd2);

        // Second 30s tick with no consumer: overrun, result stays valid.
        run_to(1080);
        check("t5_tick30", 32'(ticks_small()), 32'h7);
        small_step(1'b0, 1'b0, 1'b0);
        check("t5_result_held", 32'(bus_small.result_valid), 32'd1);
`ifdef WINDOW_SCHED_OVERRUN_EN
        check("t5_overrun", 32'(bus_small.overrun), 32'd1);
        check("t5_overrun_cnt", 32'(bus_small.overrun_cnt), 32'd1);
`endif
        small_step(1'b0, 1'b0, 1'b1);
        check("t5_result_accepted", 32'(bus_small.result_valid), 32'd0);

        // Accept coinciding with a new set event keeps result_valid and is not an overrun.
        run_to(1200);
        small_step(1'b0, 1'b0, 1'b0);
        check("t6_result_set", 32'(bus_small.result_valid), 32'd1);
        run_to(1320);
        small_step(1'b0, 1'b0, 1'b1);
        check("t6_result_kept", 32'(bus_small.result_valid), 32'd1);
`ifdef WINDOW_SCHED_OVERRUN_EN
        check("t6_overrun_cnt", 32'(bus_small.overrun_cnt), 32'd1);
`endif
        small_step(1'b0, 1'b0, 1'b1);
        check("t6_result_cleared", 32'(bus_small.result_valid), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            small_step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
